// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: load/store funct3 codes,
// ResultSrc encoding and the memory-stage LSU state type.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RES_MEM = 2'b01;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RV,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store lane replication and
// load lane extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] sdata,
  output logic [31:0] ldata
);

  logic [1:0]  eff;
  logic [7:0]  b;
  logic [15:0] h;

  // Low offset bits beyond the access size are dropped (force-align).
  always_comb begin
    eff   = 2'b00;
    b     = 8'h00;
    h     = 16'h0000;
    be    = 4'hf;
    sdata = wdata;
    ldata = rdata;
    unique case (1'b1)
      (funct3[1:0] == SZ_B): begin
        eff   = off;
        b     = rdata[{eff, 3'b000} +: 8];
        be    = 4'b0001 << eff;
        sdata = {4{wdata[7:0]}};
        ldata = funct3[2] ? {24'h0, b}
                          : {{24{b[7]}}, b};
      end
      (funct3[1:0] == SZ_H): begin
        eff   = {off[1], 1'b0};
        h     = eff[1] ? rdata[31:16]
                       : rdata[15:0];
        be    = 4'b0011 << eff;
        sdata = {2{wdata[15:0]}};
        ldata = funct3[2] ? {16'h0, h}
                          : {{16{h[15]}}, h};
      end
      default: begin
        eff = 2'b00;
      end
    endcase
    if (!store) be = 4'hf;
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit on a req/gnt/rvalid data bus.
// Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BUS_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic              tbman_selM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stallM,
  output logic [31:0]       ReadDataM,
  output logic              lsu_errM
);

  localparam bit TO_EN = BUS_TIMEOUT > 0;

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [31:0]       wd_q;
  logic [31:0]       rd_q;
  logic              err_q;
  logic [15:0]       cnt;

  logic              access;
  logic              trap;
  logic              issue;
  logic              held;
  logic              timeout;
  logic              cur_we;
  logic [2:0]        cur_f3;
  logic [1:0]        cur_off;
  logic [31:0]       cur_wd;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        be;
  logic [31:0]       sdata;
  logic [31:0]       ldata;

  assign access = (MemWriteM | (ResultSrcM == RES_MEM))
                & ~tbman_selM;

`ifdef MISALIGN_TRAP_EN
  logic misal;
  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      funct3M[1]:
        misal = ALUResultM[1:0] != 2'b00;
      (funct3M[1:0] == SZ_H):
        misal = ALUResultM[0];
      default:
        misal = 1'b0;
    endcase
  end
  assign trap = access & misal;
`else
  assign trap = 1'b0;
`endif

  assign issue = (state == IDLE) & access & ~trap;
  assign held  = state != IDLE;

  // Once issued, the bus sees only the captured copy.
  assign cur_we   = held ? we_q  : MemWriteM;
  assign cur_f3   = held ? f3_q  : funct3M;
  assign cur_off  = held ? off_q : ALUResultM[1:0];
  assign cur_wd   = held ? wd_q  : WriteDataM;
  assign cur_addr = held ? addr_q
                  : ADDR_W'(ALUResultM & 32'hffff_fffc);

  assign timeout = TO_EN
                && (int'(cnt) + 1 >= BUS_TIMEOUT);

  lsu_align u_align (
    .funct3 (cur_f3),
    .off    (cur_off),
    .store  (cur_we),
    .wdata  (cur_wd),
    .rdata  (dmem_rdata),
    .be     (be),
    .sdata  (sdata),
    .ldata  (ldata)
  );

  assign dmem_req   = n_rst & (issue | (state == REQ));
  assign dmem_we    = dmem_req & cur_we;
  assign dmem_addr  = dmem_req ? cur_addr : '0;
  assign dmem_be    = dmem_req ? be : 4'h0;
  assign dmem_wdata = dmem_req ? sdata : 32'h0;

  assign stallM = n_rst & (issue
                | (state == REQ)
                | (state == WAIT_RV));

  assign ReadDataM = rd_q;
  assign lsu_errM  = err_q
                   | (n_rst & (state == IDLE) & trap);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      addr_q <= '0;
      f3_q   <= 3'b000;
      off_q  <= 2'b00;
      we_q   <= 1'b0;
      wd_q   <= 32'h0;
      rd_q   <= 32'h0;
      err_q  <= 1'b0;
      cnt    <= 16'd0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            addr_q <= cur_addr;
            f3_q   <= funct3M;
            off_q  <= ALUResultM[1:0];
            we_q   <= MemWriteM;
            wd_q   <= WriteDataM;
            if (dmem_gnt) begin
              state <= MemWriteM ? DONE : WAIT_RV;
              cnt   <= 16'd0;
            end else begin
              state <= REQ;
              cnt   <= 16'd1;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            state <= we_q ? DONE : WAIT_RV;
            cnt   <= 16'd0;
          end else if (timeout) begin
            state <= DONE;
            err_q <= 1'b1;
            rd_q  <= 32'h0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_RV: begin
          if (dmem_rvalid) begin
            rd_q  <= ldata;
            state <= DONE;
          end else if (timeout) begin
            state <= DONE;
            err_q <= 1'b1;
            rd_q  <= 32'h0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 16'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
